// File: rtl/qproj_tile_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | qproj_tile_sequencer_if - tile-in, datapath and result-out bundle  (Rev 1.0)     |
// +----------------------------------------------------------------------------------+
interface qproj_tile_sequencer_if #(
   parameter int TILE_CNT_W = 8
);
   logic                  tile_valid;
   logic                  tile_ready;
   logic [127:0]          tile_a;
   logic [127:0]          tile_b;

   logic                  bb_write_en;
   logic [127:0]          bb_matrix_a;
   logic [127:0]          bb_matrix_b;
   logic                  bb_tile_done;
   logic                  bb_valid;
   logic [511:0]          bb_matrix_c;

   logic                  res_valid;
   logic                  res_ready;
   logic [511:0]          res_data;
   logic [TILE_CNT_W-1:0] res_idx;

   // Sequencer side.
   modport master (
      input  tile_valid, tile_a, tile_b, bb_valid, bb_matrix_c, res_ready,
      output tile_ready, bb_write_en, bb_matrix_a, bb_matrix_b, bb_tile_done,
             res_valid, res_data, res_idx
   );

   // Tile source, datapath and result sink side.
   modport slave (
      output tile_valid, tile_a, tile_b, bb_valid, bb_matrix_c, res_ready,
      input  tile_ready, bb_write_en, bb_matrix_a, bb_matrix_b, bb_tile_done,
             res_valid, res_data, res_idx
   );
endinterface
`default_nettype wire

// File: rtl/qproj_tile_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | qproj_tile_sequencer - one-tile-in-flight Q-proj sequencer; QPROJ_SEQ_PERF_EN     |
// | adds busy/stall perf counters.                                      (Rev 1.0)     |
// +----------------------------------------------------------------------------------+
module qproj_tile_sequencer #(
   parameter int DRAIN_CYCLES = 11,
   parameter int TILE_CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [TILE_CNT_W-1:0] num_tiles,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
`ifdef QPROJ_SEQ_PERF_EN
   output logic [31:0]           perf_busy_cycles,
   output logic [31:0]           perf_stall_cycles,
`endif
   qproj_tile_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   generate
      if (DRAIN_CYCLES < 9) begin : g_drain_range_bad
         $error("qproj_tile_sequencer: DRAIN_CYCLES must be >= 9");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPUTE = 3'd2,
      S_CAPTURE = 3'd3,
      S_OUTPUT  = 3'd4
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [CNT_W-1:0]      drain_cnt;
   logic [TILE_CNT_W-1:0] tile_total;
   logic [TILE_CNT_W-1:0] res_idx;
   logic [127:0]          mat_a;
   logic [127:0]          mat_b;
   logic [511:0]          res_data;
   logic                  write_en;
   logic                  tile_done;
   logic                  res_valid;

   logic                  start_acc;
   logic                  tile_hs;
   logic                  res_hs;
   logic                  last_tile;
   logic                  drain_hit;
   logic                  cap_take;
   logic                  cap_timeout;
   logic                  stray_valid;

   assign start_acc   = start && (state == S_IDLE);
   assign tile_hs     = (state == S_LOAD) && bus.tile_valid;
   assign res_hs      = (state == S_OUTPUT) && bus.res_ready;
   assign last_tile   = (res_idx == tile_total - TILE_CNT_W'(1));
   assign drain_hit   = (state == S_COMPUTE) && (drain_cnt == CNT_W'(1));
   // tile_done is high only in the first CAPTURE cycle, so its absence marks the
   // second (final) cycle of the bb_valid wait window.
   assign cap_timeout = (state == S_CAPTURE) && !bus.bb_valid && !tile_done;
   assign cap_take    = (state == S_CAPTURE) && (bus.bb_valid || !tile_done);
   assign stray_valid = bus.bb_valid && (state != S_CAPTURE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start && (num_tiles != '0)) state_nxt = S_LOAD;
         S_LOAD:    if (bus.tile_valid)             state_nxt = S_COMPUTE;
         S_COMPUTE: if (drain_hit)                  state_nxt = S_CAPTURE;
         S_CAPTURE: if (cap_take)                   state_nxt = S_OUTPUT;
         S_OUTPUT:  if (bus.res_ready)              state_nxt = last_tile ? S_IDLE : S_LOAD;
         default:                                   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         write_en   <= 1'b0;
         tile_done  <= 1'b0;
         res_valid  <= 1'b0;
         drain_cnt  <= '0;
         tile_total <= '0;
         res_idx    <= '0;
         mat_a      <= '0;
         mat_b      <= '0;
         res_data   <= '0;
      end else begin
         busy      <= (state_nxt != S_IDLE);
         done      <= (start_acc && (num_tiles == '0)) || (res_hs && last_tile);
         write_en  <= tile_hs;
         tile_done <= drain_hit;

         if (start_acc && (num_tiles != '0)) begin
            tile_total <= num_tiles;
            res_idx    <= '0;
         end

         if (tile_hs) begin
            mat_a     <= bus.tile_a;
            mat_b     <= bus.tile_b;
            drain_cnt <= CNT_W'(DRAIN_CYCLES);
         end else if ((state == S_COMPUTE) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
         end

         if (cap_take) begin
            res_data  <= bus.bb_matrix_c;
            res_valid <= 1'b1;
         end else if (res_hs) begin
            res_valid <= 1'b0;
            if (!last_tile) begin
               res_idx <= res_idx + TILE_CNT_W'(1);
            end
         end

         // A fresh error in the start cycle wins over the clear.
         if (stray_valid || cap_timeout) begin
            err <= 1'b1;
         end else if (start_acc) begin
            err <= 1'b0;
         end
      end
   end

   assign bus.tile_ready   = (state == S_LOAD);
   assign bus.bb_write_en  = write_en;
   assign bus.bb_matrix_a  = mat_a;
   assign bus.bb_matrix_b  = mat_b;
   assign bus.bb_tile_done = tile_done;
   assign bus.res_valid    = res_valid;
   assign bus.res_data     = res_data;
   assign bus.res_idx      = res_idx;

`ifdef QPROJ_SEQ_PERF_EN
   logic stall_now;

   assign stall_now = ((state == S_LOAD) && !bus.tile_valid) || (res_valid && !bus.res_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else if (start_acc) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (busy && (perf_busy_cycles != '1)) begin
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
         end
         if (stall_now && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
